// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port Avalon-MM arbiter (audio writes, video burst reads) into the SDRAM controller
module sdram_port_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int BURST_W      = 4,
  parameter int MAX_PEND     = 16,
  parameter int STARVE_LIMIT = 4,
  localparam int PEND_W      = $clog2(MAX_PEND + 1)
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  // audio capture writer
  input  logic              aud_req,
  input  logic [ADDR_W-1:0] aud_addr,
  input  logic [31:0]       aud_wdata,
  output logic              aud_ack,
  // video scanout reader
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [BURST_W-1:0] vid_burstcount,
  output logic              vid_ack,
  output logic [31:0]       vid_rdata,
  output logic              vid_rvalid,
  // master toward the SDRAM controller slave
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  output logic [BURST_W-1:0] m_burstcount,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  // status
  output logic [PEND_W-1:0] pend_beats,
  output logic              rd_err
);

  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam int SUM_W = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AUD_WR = 2'd1,
    VID_RD = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_address;
  logic [31:0]        r_writedata;
  logic               r_write;
  logic               r_read;
  logic [BURST_W-1:0] r_burstcount;
  logic [SW-1:0]      r_starve;
  logic [PEND_W-1:0]  r_pend;
  logic               r_rd_err;
  logic [31:0]        r_vid_rdata;
  logic               r_vid_rvalid;

  logic [BURST_W-1:0] w_vid_bc_eff;
  logic [SUM_W-1:0]   w_vid_need;
  logic               w_vid_elig;
  logic               w_starved;
  logic               w_grant_vid;
  logic               w_grant_aud;
  logic               w_aud_accept;
  logic               w_vid_accept;
  logic               w_rd_beat;
  logic [PEND_W-1:0]  w_pend_inc;
  logic [PEND_W-1:0]  w_pend_dec;

  // A zero burstcount from the reader still moves one beat.
  assign w_vid_bc_eff = (vid_burstcount == '0) ? BURST_W'(1) : vid_burstcount;

  // Video may only start a burst whose beats all fit in the in-flight budget.
  assign w_vid_need = SUM_W'(r_pend) + SUM_W'(w_vid_bc_eff);
  assign w_vid_elig = vid_req && (w_vid_need <= SUM_W'(MAX_PEND));
  assign w_starved  = (r_starve == SW'(STARVE_LIMIT));

  // Audio wins unless video has been passed over STARVE_LIMIT times in a row.
  assign w_grant_vid = (r_state == IDLE) && w_vid_elig && (w_starved || !aud_req);
  assign w_grant_aud = (r_state == IDLE) && aud_req && !(w_starved && w_vid_elig);

  // A command is accepted in the first cycle it is on the bus without a stall.
  assign w_aud_accept = (r_state == AUD_WR) && !m_waitrequest;
  assign w_vid_accept = (r_state == VID_RD) && !m_waitrequest;

  // Beats arriving with nothing outstanding are flagged, not counted.
  assign w_rd_beat  = m_readdatavalid && (r_pend != '0);
  assign w_pend_inc = w_vid_accept ? PEND_W'(r_burstcount) : '0;
  assign w_pend_dec = w_rd_beat ? PEND_W'(1) : '0;

  // Command FSM: captures the winning request and holds it on the bus until accepted.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state      <= IDLE;
      r_address    <= '0;
      r_writedata  <= '0;
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_burstcount <= BURST_W'(1);
      r_starve     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_vid) begin
            r_address    <= vid_addr;
            r_burstcount <= w_vid_bc_eff;
            r_read       <= 1'b1;
            r_starve     <= '0;
            r_state      <= VID_RD;
          end else if (w_grant_aud) begin
            r_address    <= aud_addr;
            r_writedata  <= aud_wdata;
            r_burstcount <= BURST_W'(1);
            r_write      <= 1'b1;
            if (vid_req && !w_starved) begin
              r_starve <= r_starve + SW'(1);
            end
            r_state      <= AUD_WR;
          end
        end
        AUD_WR: begin
          if (!m_waitrequest) begin
            r_write <= 1'b0;
            r_state <= IDLE;
          end
        end
        VID_RD: begin
          if (!m_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_write <= 1'b0;
          r_read  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outstanding read beat count and sticky underflow error.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_pend   <= '0;
      r_rd_err <= 1'b0;
    end else begin
      r_pend <= r_pend + w_pend_inc - w_pend_dec;
      if (m_readdatavalid && (r_pend == '0)) begin
        r_rd_err <= 1'b1;
      end
    end
  end

  // Read data is forwarded to the video reader one cycle late, spurious beats included.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_vid_rdata  <= '0;
      r_vid_rvalid <= 1'b0;
    end else begin
      r_vid_rdata  <= m_readdata;
      r_vid_rvalid <= m_readdatavalid;
    end
  end

  assign aud_ack      = w_aud_accept;
  assign vid_ack      = w_vid_accept;
  assign vid_rdata    = r_vid_rdata;
  assign vid_rvalid   = r_vid_rvalid;
  assign m_address    = r_address;
  assign m_read       = r_read;
  assign m_write      = r_write;
  assign m_writedata  = r_writedata;
  assign m_byteenable = 4'hF;
  assign m_burstcount = r_burstcount;
  assign pend_beats   = r_pend;
  assign rd_err       = r_rd_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  logic        clk_clk;
  logic        reset_reset_n;
  logic        aud_req;
  logic [23:0] aud_addr;
  logic [31:0] aud_wdata;
  logic        aud_ack;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic [3:0]  vid_burstcount;
  logic        vid_ack;
  logic [31:0] vid_rdata;
  logic        vid_rvalid;
  logic [23:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [3:0]  m_burstcount;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic [4:0]  pend_beats;
  logic        rd_err;

  int vectors;
  int errors;

  sdram_port_arbiter dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .aud_req        (aud_req),
    .aud_addr       (aud_addr),
    .aud_wdata      (aud_wdata),
    .aud_ack        (aud_ack),
    .vid_req        (vid_req),
    .vid_addr       (vid_addr),
    .vid_burstcount (vid_burstcount),
    .vid_ack        (vid_ack),
    .vid_rdata      (vid_rdata),
    .vid_rvalid     (vid_rvalid),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_writedata    (m_writedata),
    .m_byteenable   (m_byteenable),
    .m_burstcount   (m_burstcount),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .pend_beats     (pend_beats),
    .rd_err         (rd_err)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [15:0] seq;
    int          n;

    vectors         = 0;
    errors          = 0;
    reset_reset_n   = 1'b0;
    aud_req         = 1'b0;
    aud_addr        = '0;
    aud_wdata       = '0;
    vid_req         = 1'b0;
    vid_addr        = '0;
    vid_burstcount  = '0;
    m_waitrequest   = 1'b0;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;

    // reset state
    repeat (2) cyc();
    chk("rst_m_write",   32'(m_write), 0);
    chk("rst_m_read",    32'(m_read), 0);
    chk("rst_m_addr",    32'(m_address), 0);
    chk("rst_byteen",    32'(m_byteenable), 32'hF);
    chk("rst_burst",     32'(m_burstcount), 1);
    chk("rst_pend",      32'(pend_beats), 0);
    chk("rst_rd_err",    32'(rd_err), 0);
    chk("rst_aud_ack",   32'(aud_ack), 0);
    chk("rst_vid_ack",   32'(vid_ack), 0);
    chk("rst_vid_rvalid", 32'(vid_rvalid), 0);
    reset_reset_n = 1'b1;
    cyc();

    // audio write stalled three cycles
    aud_req       = 1'b1;
    aud_addr      = 24'h000100;
    aud_wdata     = 32'hDEADBEEF;
    m_waitrequest = 1'b1;
    cyc();
    chk("aud_wr_c1",   32'(m_write), 1);
    chk("aud_addr",    32'(m_address), 32'h100);
    chk("aud_wdata",   m_writedata, 32'hDEADBEEF);
    chk("aud_burst",   32'(m_burstcount), 1);
    chk("aud_ack_c1",  32'(aud_ack), 0);
    cyc();
    chk("aud_wr_c2",   32'(m_write), 1);
    chk("aud_ack_c2",  32'(aud_ack), 0);
    cyc();
    chk("aud_wr_c3",   32'(m_write), 1);
    chk("aud_ack_c3",  32'(aud_ack), 0);
    m_waitrequest = 1'b0;
    settle();
    chk("aud_wr_c4",   32'(m_write), 1);
    chk("aud_ack_c4",  32'(aud_ack), 1);
    cyc();
    chk("aud_wr_drop", 32'(m_write), 0);
    chk("aud_ack_end", 32'(aud_ack), 0);
    aud_req = 1'b0;
    cyc();
    chk("aud_idle",    32'(m_write), 0);

    // video burst of 8
    vid_req        = 1'b1;
    vid_addr       = 24'h002000;
    vid_burstcount = 4'd8;
    cyc();
    chk("vid_rd",      32'(m_read), 1);
    chk("vid_addr",    32'(m_address), 32'h2000);
    chk("vid_burst",   32'(m_burstcount), 8);
    settle();
    chk("vid_ack_on",  32'(vid_ack), 1);
    cyc();
    chk("vid_rd_drop", 32'(m_read), 0);
    chk("vid_ack_off", 32'(vid_ack), 0);
    chk("vid_pend8",   32'(pend_beats), 8);
    vid_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_readdatavalid = 1'b1;
      m_readdata      = 32'(i);
      cyc();
      chk("beat_rvalid", 32'(vid_rvalid), 1);
      chk("beat_rdata",  vid_rdata, 32'(i));
      chk("beat_pend",   32'(pend_beats), 32'(7 - i));
    end
    m_readdatavalid = 1'b0;
    cyc();
    chk("burst_rvalid_off", 32'(vid_rvalid), 0);
    chk("burst_pend0",      32'(pend_beats), 0);
    chk("burst_no_err",     32'(rd_err), 0);

    // contention with both requesters held high
    aud_req        = 1'b1;
    aud_addr       = 24'h000200;
    aud_wdata      = 32'h12345678;
    vid_req        = 1'b1;
    vid_addr       = 24'h003000;
    vid_burstcount = 4'd1;
    seq            = '0;
    n              = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if ((m_write || m_read) && n < 16) begin
        seq[n] = m_read;
        n++;
      end
    end
    aud_req = 1'b0;
    vid_req = 1'b0;
    chk("cont_ncmds", 32'(n), 10);
    chk("cont_order", 32'(seq), 32'b1000010000);
    cyc();
    chk("cont_idle",  32'(m_write | m_read), 0);
    chk("cont_pend",  32'(pend_beats), 2);
    m_readdatavalid = 1'b1;
    cyc();
    cyc();
    m_readdatavalid = 1'b0;
    chk("cont_drain", 32'(pend_beats), 0);

    // pending limit: two bursts of 8 fill the budget
    vid_req        = 1'b1;
    vid_burstcount = 4'd8;
    cyc();
    chk("lim_rd1",   32'(m_read), 1);
    cyc();
    chk("lim_pend8", 32'(pend_beats), 8);
    cyc();
    chk("lim_rd2",   32'(m_read), 1);
    cyc();
    chk("lim_pend16", 32'(pend_beats), 16);
    vid_burstcount = 4'd1;
    cyc();
    chk("lim_block1", 32'(m_read), 0);
    cyc();
    chk("lim_block2", 32'(m_read), 0);
    m_readdatavalid = 1'b1;
    cyc();
    m_readdatavalid = 1'b0;
    chk("lim_block3", 32'(m_read), 0);
    chk("lim_pend15", 32'(pend_beats), 15);
    cyc();
    chk("lim_grant",  32'(m_read), 1);
    chk("lim_burst1", 32'(m_burstcount), 1);
    vid_req = 1'b0;
    cyc();
    chk("lim_pend16b", 32'(pend_beats), 16);

    // drain to 3, then accept a burst of 4 alongside a returning beat
    m_readdatavalid = 1'b1;
    repeat (13) cyc();
    m_readdatavalid = 1'b0;
    chk("sim_pend3", 32'(pend_beats), 3);
    vid_req        = 1'b1;
    vid_burstcount = 4'd4;
    cyc();
    chk("sim_rd",    32'(m_read), 1);
    chk("sim_burst", 32'(m_burstcount), 4);
    m_readdatavalid = 1'b1;
    cyc();
    m_readdatavalid = 1'b0;
    vid_req         = 1'b0;
    chk("sim_pend6", 32'(pend_beats), 6);
    m_readdatavalid = 1'b1;
    repeat (6) cyc();
    m_readdatavalid = 1'b0;
    chk("sim_pend0", 32'(pend_beats), 0);
    chk("sim_noerr", 32'(rd_err), 0);

    // spurious beat with nothing outstanding
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h00000BAD;
    cyc();
    m_readdatavalid = 1'b0;
    chk("spur_err",    32'(rd_err), 1);
    chk("spur_pend",   32'(pend_beats), 0);
    chk("spur_rvalid", 32'(vid_rvalid), 1);
    chk("spur_rdata",  vid_rdata, 32'hBAD);
    repeat (3) cyc();
    chk("spur_sticky", 32'(rd_err), 1);
    chk("spur_pend2",  32'(pend_beats), 0);

    // reset in the middle of a stalled audio write
    m_waitrequest  = 1'b1;
    aud_req        = 1'b1;
    aud_addr       = 24'h000055;
    aud_wdata      = 32'hCAFEF00D;
    vid_req        = 1'b1;
    vid_burstcount = 4'd1;
    cyc();
    chk("mid_wr1",    32'(m_write), 1);
    chk("mid_starve", 32'(dut.r_starve), 1);
    cyc();
    chk("mid_wr2",    32'(m_write), 1);
    reset_reset_n = 1'b0;
    settle();
    chk("mid_rst_wr",     32'(m_write), 0);
    chk("mid_rst_ack",    32'(aud_ack), 0);
    chk("mid_rst_addr",   32'(m_address), 0);
    chk("mid_rst_burst",  32'(m_burstcount), 1);
    chk("mid_rst_pend",   32'(pend_beats), 0);
    chk("mid_rst_err",    32'(rd_err), 0);
    chk("mid_rst_state",  32'(dut.r_state), 0);
    chk("mid_rst_starve", 32'(dut.r_starve), 0);
    aud_req       = 1'b0;
    vid_req       = 1'b0;
    m_waitrequest = 1'b0;
    repeat (2) cyc();
    chk("mid_hold_ack", 32'(aud_ack), 0);
    chk("mid_hold_wr",  32'(m_write), 0);
    reset_reset_n = 1'b1;
    repeat (2) cyc();
    chk("post_rst_wr", 32'(m_write), 0);
    chk("post_rst_rd", 32'(m_read), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
